// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester arbiter/sequencer in front of a single-port memory
// (async read, sync write). Port 0 is instruction fetch and port 1 is load/store data.
// The winning request is latched and driven to memory for one cycle. The read word is
// registered and then returned with a one-cycle ack. Sequence: IDLE -> ACCESS -> RESP.
// Optional feature: define ARB_ROUND_ROBIN_EN to resolve ties round-robin. When it is
// undefined, ties use fixed priority and port 1 wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t              r_state, w_state_d;
    logic                r_mem_we, w_mem_we_d;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_d;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_d;
    logic [DATA_W-1:0]   r_rdata0, w_rdata0_d;
    logic [DATA_W-1:0]   r_rdata1, w_rdata1_d;
    logic                r_ack0, w_ack0_d;
    logic                r_ack1, w_ack1_d;
    logic                r_busy, w_busy_d;
    logic                r_grant, w_grant_d;
    logic                w_win;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_ptr;

    // On a tie the port not granted last wins; a lone requester always wins.
    assign w_win = (req0 && req1) ? ~r_rr_ptr : req1;

    // Round-robin pointer remembers the port of the most recent grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr <= 1'b0;
        end else if (r_state == StIdle && (req0 || req1)) begin
            r_rr_ptr <= w_win;
        end
    end
`else
    // Fixed priority: data port wins every tie.
    assign w_win = req1;
`endif

    // Next-state and next-output decode; every registered value holds unless changed.
    always_comb begin
        w_state_d     = r_state;
        w_mem_we_d    = r_mem_we;
        w_mem_addr_d  = r_mem_addr;
        w_mem_wdata_d = r_mem_wdata;
        w_rdata0_d    = r_rdata0;
        w_rdata1_d    = r_rdata1;
        w_ack0_d      = 1'b0;
        w_ack1_d      = 1'b0;
        w_busy_d      = r_busy;
        w_grant_d     = r_grant;
        unique case (r_state)
            StIdle: begin
                if (req0 || req1) begin
                    w_grant_d = w_win;
                    if (w_win) begin
                        w_mem_we_d    = we1;
                        w_mem_addr_d  = addr1;
                        w_mem_wdata_d = wdata1;
                    end else begin
                        w_mem_we_d    = we0;
                        w_mem_addr_d  = addr0;
                        w_mem_wdata_d = wdata0;
                    end
                    w_busy_d  = 1'b1;
                    w_state_d = StAccess;
                end
            end
            StAccess: begin
                // Async read sees the pre-write word; a write commits at this same edge.
                if (r_grant) begin
                    w_rdata1_d = mem_rdata;
                    w_ack1_d   = 1'b1;
                end else begin
                    w_rdata0_d = mem_rdata;
                    w_ack0_d   = 1'b1;
                end
                w_mem_we_d = 1'b0;
                w_state_d  = StResp;
            end
            StResp: begin
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end
            default: begin
                w_mem_we_d = 1'b0;
                w_busy_d   = 1'b0;
                w_state_d  = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset is asynchronous so mem_we drops at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_busy      <= 1'b0;
            r_grant     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_mem_we    <= w_mem_we_d;
            r_mem_addr  <= w_mem_addr_d;
            r_mem_wdata <= w_mem_wdata_d;
            r_rdata0    <= w_rdata0_d;
            r_rdata1    <= w_rdata1_d;
            r_ack0      <= w_ack0_d;
            r_ack1      <= w_ack1_d;
            r_busy      <= w_busy_d;
            r_grant     <= w_grant_d;
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign busy      = r_busy;
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural memory model, directed steps and a
// scoreboard of expected (port, rdata) results popped on each ack.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, mem_we, busy, grant_id;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] mem    [64];
    logic [DW-1:0] shadow [64];

    typedef struct packed {
        logic          port;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    int            checks = 0;
    int            failures = 0;
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .rdata1    (rdata1),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    // Memory model: async read, sync write, with a bench-side preload path.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a request and push its expected result (pre-write word for writes).
    task automatic issue(input logic port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        exp_t e;
        e.port  = port;
        e.rdata = shadow[addr];
        sb.push_back(e);
        if (we) shadow[addr] = wdata;
        if (port) begin
            req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
        end
    endtask

    task automatic drop(input logic port);
        if (port) begin req1 = 1'b0; we1 = 1'b0; end
        else begin req0 = 1'b0; we0 = 1'b0; end
    endtask

    // Wait (bounded) for the next ack, pop the scoreboard and compare.
    task automatic wait_resp(input int exp_we_cyc, input string tag);
        int   n;
        int   wec;
        logic got;
        exp_t e;
        n = 0; wec = 0; got = 1'b0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_we === 1'b1) wec++;
            if (ack0 === 1'b1 || ack1 === 1'b1) got = 1'b1;
        end
        check({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
        if (!got) return;
        check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        if (e.port) exp_rd1 = e.rdata; else exp_rd0 = e.rdata;
        check({tag, "_latency"}, n, 32'd2);
        check({tag, "_ack1"}, {31'd0, ack1}, {31'd0, e.port});
        check({tag, "_ack0"}, {31'd0, ack0}, {31'd0, ~e.port});
        check({tag, "_grant"}, {31'd0, grant_id}, {31'd0, e.port});
        check({tag, "_rdata0"}, rdata0, exp_rd0);
        check({tag, "_rdata1"}, rdata1, exp_rd1);
        check({tag, "_we_cycles"}, wec, exp_we_cyc);
        @(negedge clk);
        check({tag, "_ack_pulse"}, {30'd0, ack0, ack1}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 32'h1000_0000 + i;
        shadow[0] = 32'h2008_0005;
        shadow[5] = 32'h0;
        shadow[9] = 32'h1;

        // 1. Reset mid-cycle, preload, then idle.
        #7 reset_n = 1'b0;
        #1;
        check("rst_ack", {30'd0, ack0, ack1}, 32'd0);
        check("rst_we_busy_gid", {29'd0, mem_we, busy, grant_id}, 32'd0);
        check("rst_addr", {26'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = AW'(i); pre_data = shadow[i];
        end
        @(negedge clk);
        pre_we  = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // 2. Port 1 write then read of addr 5.
        @(negedge clk); issue(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
        wait_resp(1, "p1_write5"); drop(1'b1);
        @(negedge clk); issue(1'b1, 1'b0, 6'd5, 32'h0);
        wait_resp(0, "p1_read5"); drop(1'b1);
        check("p1_read5_value", rdata1, 32'hDEAD_BEEF);

        // 3. Fetch read of addr 0.
        @(negedge clk); issue(1'b0, 1'b0, 6'd0, 32'h0);
        wait_resp(0, "p0_fetch0"); drop(1'b0);
        check("p0_fetch0_value", rdata0, 32'h2008_0005);

        // 5. Read-during-write on addr 9.
        @(negedge clk); issue(1'b1, 1'b1, 6'd9, 32'h2);
        wait_resp(1, "p1_rdw9"); drop(1'b1);
        check("p1_rdw9_old", rdata1, 32'h1);
        @(negedge clk); issue(1'b1, 1'b0, 6'd9, 32'h0);
        wait_resp(0, "p1_read9"); drop(1'b1);
        check("p1_read9_new", rdata1, 32'h2);

        // 6. Reset during the ACCESS cycle of a write.
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 6'd12; wdata1 = 32'hCAFE_F00D;
        @(posedge clk); #2;
        check("rsta_we_before", {31'd0, mem_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("rsta_we_after", {31'd0, mem_we}, 32'd0);
        check("rsta_busy", {31'd0, busy}, 32'd0);
        drop(1'b1);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        exp_rd0 = '0; exp_rd1 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rsta_no_ack", {29'd0, ack0, ack1, busy}, 32'd0);
        end
        check("rsta_write_lost", mem[12], shadow[12]);

        // 4. Tie: both requests rise together.
        @(negedge clk);
        issue(1'b1, 1'b0, 6'd5, 32'h0);
        issue(1'b0, 1'b0, 6'd0, 32'h0);
`ifdef ARB_ROUND_ROBIN_EN
        sb.push_back({1'b1, shadow[5]});
        sb.push_back({1'b0, shadow[0]});
        wait_resp(0, "rr_tie_a");
        wait_resp(0, "rr_tie_b");
        wait_resp(0, "rr_tie_c");
        wait_resp(0, "rr_tie_d");
        drop(1'b0); drop(1'b1);
`else
        wait_resp(0, "fp_tie_first");
        drop(1'b1);
        wait_resp(0, "fp_tie_second");
        drop(1'b0);
`endif
        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
